vga_ctrl: RTL and testbench
===========================

Name: vga_ctrl

Overview:
- VGA timing generator and pixel output stage for the display path.
- Sits directly downstream of the clock-divider/enable stage, which supplies the pixel-rate enable on `clken`. Default timing is 640x480@60: 25 MHz pixel rate from a 50 MHz `clkin`.
- Produces the pixel address for the video memory and sync signals, and registers the returned RGB data onto the VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clkin  in  1  system clock; the only clock
rst  in  1  synchronous reset, active-high
clken  in  1  pixel enable from the divider stage; counters and outputs advance only when high
vga_data  in  12  RGB444 for the current address {R[11:8],G[7:4],B[3:0]}, combinational from memory in the same cycle
h_addr  out  10  current pixel column (0..H_ACTIVE-1 when visible)
v_addr  out  10  current line (0..V_ACTIVE-1 when visible)
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
valid  out  1  high when the registered RGB belongs to the visible area
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
frame_tick  out  1  one-`clkin` pulse at each frame wrap

Behaviour:

Derived constants:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800).
- V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).

Counters:
- `h_cnt` counts 0..H_TOTAL-1 and `v_cnt` counts 0..V_TOTAL-1; both are 10-bit unsigned.
- Each counter holds when `clken` is 0.
- With `clken` = 1: `h_cnt` increments. At H_TOTAL-1 it wraps to 0, and `v_cnt` increments in that same cycle.
- `v_cnt` wraps to 0 after V_TOTAL-1 when `h_cnt` also wraps.

Line layout (per `h_cnt`; identical structure for `v_cnt` with V_* parameters):
- Active region: 0..H_ACTIVE-1.
- Front porch follows the active region.
- Sync region: [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- Back porch follows the sync region.

Address outputs:
- `h_addr` = `h_cnt` and `v_addr` = `v_cnt`, taken directly from the counter registers with no extra delay.
- Outside the active region the addresses keep counting. Consumers must gate on `valid`, not on the address values.

Output stage (registered; updates only on `clkin` edges with `clken` = 1):
- `hsync` <= 0 iff `h_cnt` is in the H sync range, else 1.
- `vsync` <= 0 iff `v_cnt` is in the V sync range, else 1.
- `valid` <= (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- {`vga_r`, `vga_g`, `vga_b`} <= `vga_data` when that `valid` term is true, else 0.
- Net effect: the address is presented in enabled cycle N; sync, `valid` and RGB for that address appear after enabled cycle N's edge, i.e. one pixel of latency. Sync and RGB are always mutually aligned.

`frame_tick`:
- Registered. High for exactly one `clkin` cycle after the edge on which `clken` = 1, `h_cnt` = H_TOTAL-1 and `v_cnt` = V_TOTAL-1.
- 0 in all other cycles, including cycles where `clken` = 0.

Reset (`rst` = 1 at a `clkin` edge; takes priority over `clken`):
- `h_cnt` = 0, `v_cnt` = 0.
- `hsync` = 1, `vsync` = 1, `valid` = 0, RGB = 0, `frame_tick` = 0.
- Reset mid-line or mid-frame abandons the frame. The first enabled cycle after reset presents address (0,0).

Boundary conditions:
- `clken` held at 0: all state frozen, `frame_tick` = 0.
- `clken` tied to 1: the block runs at the `clkin` rate.
- `vga_data` is ignored whenever the pixel is not visible; blanking is forced to 0 regardless of memory contents.

Decomposition:
- Shared package `vga_pkg`:
  - 640x480@60 timing constants (the parameter defaults above) and derived H_TOTAL/V_TOTAL.
  - Counter width constant (10).
  - RGB444 field positions.
- One natural sub-module, `vga_counter`: a parameterised wrap counter with an enable and a carry-out. Instantiate it twice, chaining the h carry into the v enable.
- Sync decode and the output register stay in `vga_ctrl`.

Test Plan:
1. Reset then `clken` = 1 every cycle → first visible RGB one cycle after address (0,0); `hsync` falls after address 656 and rises after address 752 (96 cycles low); line period 800 cycles.
2. `clken` pulsed every 2nd `clkin` (the divider at 25 MHz from 50 MHz) → line period 1600 `clkin` cycles, hsync low for 192 `clkin` cycles, outputs change only after enabled edges.
3. Run a full frame → `vsync` low for exactly 2 lines (`v_cnt` 490..491); `frame_tick` is one `clkin` wide with exactly 420000 `clkin` cycles between ticks at full enable.
4. `vga_data` = 12'hFFF held constant → RGB = F/F/F only while `valid`=1; RGB = 0 for `h_cnt` 640..799 and for lines 480..524; 640 visible pixels per line.
5. Assert `rst` at `h_cnt` = 300, `v_cnt` = 200 with `clken` = 1 → next cycle `hsync`=`vsync`=1, `valid`=0, address = (0,0), no `frame_tick`.
6. Hold `clken` = 0 for 50 cycles mid-line → `h_addr`, `v_addr`, sync and RGB are unchanged throughout; counting resumes from the frozen value.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA display path.
//   - 640x480@60 default timing (pixels / lines) and derived totals
//   - counter width used for h/v counters and addresses
//   - RGB444 field positions inside the 12-bit memory word and a packed pixel type
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W = 10;

  // RGB444 word layout: {R[11:8], G[7:4], B[3:0]}
  localparam int RGB_W = 12;
  localparam int R_HI  = 11;
  localparam int R_LO  = 8;
  localparam int G_HI  = 7;
  localparam int G_LO  = 4;
  localparam int B_HI  = 3;
  localparam int B_LO  = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_counter.sv
// vga_counter: wrap counter 0..TOTAL-1 with enable and carry-out.
// Ports:
//   clkin  - clock
//   rst    - synchronous active-high reset, clears the count
//   en     - count enable; count holds when low
//   cnt    - current count
//   carry  - high while en is high and cnt is at TOTAL-1 (the count wraps on
//            this edge); used to enable the next counter in a chain
module vga_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = VGA_H_TOTAL,
  parameter int W     = CNT_W
) (
  input  logic         clkin,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign carry = en && (cnt == LAST);

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= carry ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_ctrl.sv
// vga_ctrl: VGA timing generator and registered pixel output stage.
// Ports:
//   clkin      - system clock (only clock)
//   rst        - synchronous active-high reset
//   clken      - pixel-rate enable; everything advances only when high
//   vga_data   - RGB444 from video memory for the current address (same cycle)
//   h_addr     - current pixel column (counter value, keeps counting in blanking)
//   v_addr     - current line (counter value, keeps counting in blanking)
//   hsync      - horizontal sync, active-low, one pixel behind the address
//   vsync      - vertical sync, active-low, one pixel behind the address
//   valid      - registered RGB belongs to the visible area
//   vga_r/g/b  - registered colour, forced to 0 outside the visible area
//   frame_tick - one clkin pulse after the edge that wraps the frame
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             clken,
  input  logic [RGB_W-1:0] vga_data,
  output logic [CNT_W-1:0] h_addr,
  output logic [CNT_W-1:0] v_addr,
  output logic             hsync,
  output logic             vsync,
  output logic             valid,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic in_span(input logic [CNT_W-1:0] c, lo, hi);
    return (c >= lo) && (c <= hi);
  endfunction

  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;
  logic             h_wrap;
  logic             v_wrap;
  logic             vis_p0;

  logic             hsync_p1;
  logic             vsync_p1;
  logic             vld_p1;
  rgb444_t          rgb_p1;
  logic             frame_tick_p1;

  // ---- stage p0: h/v position counters; addresses come straight from here
  vga_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clkin (clkin),
    .rst   (rst),
    .en    (clken),
    .cnt   (h_cnt_p0),
    .carry (h_wrap)
  );

  // The vertical counter advances only on the edge that wraps the line.
  vga_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clkin (clkin),
    .rst   (rst),
    .en    (h_wrap),
    .cnt   (v_cnt_p0),
    .carry (v_wrap)
  );

  assign h_addr = h_cnt_p0;
  assign v_addr = v_cnt_p0;
  assign vis_p0 = (h_cnt_p0 < H_VIS_END) && (v_cnt_p0 < V_VIS_END);

  // ---- stage p1: sync, valid and colour for the address presented in p0
  always_ff @(posedge clkin) begin
    if (rst) begin
      hsync_p1      <= 1'b1;
      vsync_p1      <= 1'b1;
      vld_p1        <= 1'b0;
      rgb_p1        <= '0;
      frame_tick_p1 <= 1'b0;
    end else begin
      // v_wrap already implies clken, so the tick never fires on idle cycles.
      frame_tick_p1 <= v_wrap;
      if (clken) begin
        hsync_p1 <= !in_span(h_cnt_p0, H_SYNC_LO, H_SYNC_HI);
        vsync_p1 <= !in_span(v_cnt_p0, V_SYNC_LO, V_SYNC_HI);
        vld_p1   <= vis_p0;
        if (vis_p0) begin
          rgb_p1 <= '{r: vga_data[R_HI:R_LO], g: vga_data[G_HI:G_LO], b: vga_data[B_HI:B_LO]};
        end else begin
          rgb_p1 <= '0;
        end
      end
    end
  end

  assign hsync      = hsync_p1;
  assign vsync      = vsync_p1;
  assign valid      = vld_p1;
  assign vga_r      = rgb_p1.r;
  assign vga_g      = rgb_p1.g;
  assign vga_b      = rgb_p1.b;
  assign frame_tick = frame_tick_p1;

endmodule

// File: tb/tb_vga_ctrl.sv
// tb_vga_ctrl: drives a default 640x480 instance and a shrunken-timing
// instance with identical stimulus and compares both against a position
// model computed from the number of enabled pixels since reset.
module tb_vga_ctrl;

  localparam int HA [2] = '{640, 40};
  localparam int HF [2] = '{16, 4};
  localparam int HS [2] = '{96, 8};
  localparam int HB [2] = '{48, 4};
  localparam int VA [2] = '{480, 12};
  localparam int VF [2] = '{10, 2};
  localparam int VS [2] = '{2, 2};
  localparam int VB [2] = '{33, 3};

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b0;
  logic [11:0] vga_data = 12'h000;

  logic [9:0]  h_addr [2];
  logic [9:0]  v_addr [2];
  logic        hsync [2];
  logic        vsync [2];
  logic        valid [2];
  logic [3:0]  vga_r [2];
  logic [3:0]  vga_g [2];
  logic [3:0]  vga_b [2];
  logic        frame_tick [2];

  int total = 0;
  int bad = 0;

  always #5 clkin = ~clkin;

  vga_ctrl u_a (
    .clkin(clkin), .rst(rst), .clken(clken), .vga_data(vga_data),
    .h_addr(h_addr[0]), .v_addr(v_addr[0]), .hsync(hsync[0]), .vsync(vsync[0]),
    .valid(valid[0]), .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]),
    .frame_tick(frame_tick[0])
  );

  vga_ctrl #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_b (
    .clkin(clkin), .rst(rst), .clken(clken), .vga_data(vga_data),
    .h_addr(h_addr[1]), .v_addr(v_addr[1]), .hsync(hsync[1]), .vsync(vsync[1]),
    .valid(valid[1]), .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]),
    .frame_tick(frame_tick[1])
  );

  // ---------------- reference model ----------------
  longint      n [2];          // enabled pixels since reset
  logic        m_hs [2];
  logic        m_vs [2];
  logic        m_vl [2];
  logic        m_ft [2];
  logic [11:0] m_rgb [2];

  function automatic int htot(int d);
    return HA[d] + HF[d] + HS[d] + HB[d];
  endfunction

  function automatic int vtot(int d);
    return VA[d] + VF[d] + VS[d] + VB[d];
  endfunction

  function automatic int cur_h(int d);
    return int'(n[d] % longint'(htot(d)));
  endfunction

  function automatic int cur_v(int d);
    return int'((n[d] / longint'(htot(d))) % longint'(vtot(d)));
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        n[d] = 0; m_hs[d] = 1'b1; m_vs[d] = 1'b1; m_vl[d] = 1'b0;
        m_rgb[d] = 12'h000; m_ft[d] = 1'b0;
      end else if (clken) begin
        int h;
        int v;
        h = cur_h(d);
        v = cur_v(d);
        m_hs[d]  = !((h >= HA[d] + HF[d]) && (h < HA[d] + HF[d] + HS[d]));
        m_vs[d]  = !((v >= VA[d] + VF[d]) && (v < VA[d] + VF[d] + VS[d]));
        m_vl[d]  = (h < HA[d]) && (v < VA[d]);
        m_rgb[d] = m_vl[d] ? vga_data : 12'h000;
        m_ft[d]  = (h == htot(d) - 1) && (v == vtot(d) - 1);
        n[d]++;
      end else begin
        m_ft[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [35:0] exp_vec(int d);
    return {10'(cur_h(d)), 10'(cur_v(d)), m_hs[d], m_vs[d], m_vl[d], m_rgb[d], m_ft[d]};
  endfunction

  function automatic logic [35:0] obs_vec(int d);
    return {h_addr[d], v_addr[d], hsync[d], vsync[d], valid[d],
            vga_r[d], vga_g[d], vga_b[d], frame_tick[d]};
  endfunction

  // Per-cycle trace recorder; each test judges the accumulated result itself.
  int          sb_err;
  int          sb_dut;
  logic [35:0] sb_obs;
  logic [35:0] sb_exp;

  task automatic sb_clear();
    sb_err = 0; sb_dut = 0; sb_obs = '0; sb_exp = '0;
  endtask

  task automatic tick();
    @(posedge clkin);
    model_edge();
    #1;
    for (int d = 0; d < 2; d++) begin
      if (obs_vec(d) !== exp_vec(d)) begin
        if (sb_err == 0) begin
          sb_dut = d; sb_obs = obs_vec(d); sb_exp = exp_vec(d);
        end
        sb_err++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clken = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [35:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    rst = 1'b1;
    clken = 1'b0;
    vga_data = 12'hABC;
    tick();
    clken = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== rst_vec) begin
        bad++;
        $display("FAIL reset_state dut%0d: got %h want %h", d, obs_vec(d), rst_vec);
      end
    end
  endtask

  task automatic test_full_rate();
    int fall0, fall1, rise0;
    logic prev;
    logic [11:0] d0;
    sb_clear();
    do_reset();
    d0 = 12'($urandom_range(1, 4095));
    vga_data = d0;
    tick();
    total++;
    if (valid[0] !== 1'b1 || {vga_r[0], vga_g[0], vga_b[0]} !== d0 || h_addr[0] !== 10'd1) begin
      bad++;
      $display("FAIL first_pixel: valid=%b rgb=%h h=%0d want valid=1 rgb=%h h=1",
               valid[0], {vga_r[0], vga_g[0], vga_b[0]}, h_addr[0], d0);
    end
    fall0 = -1; fall1 = -1; rise0 = -1;
    prev = hsync[0];
    for (int k = 0; k < 1700; k++) begin
      vga_data = 12'($urandom);
      tick();
      if (prev === 1'b1 && hsync[0] === 1'b0) begin
        if (fall0 < 0) begin
          fall0 = k;
          total++;
          if (h_addr[0] !== 10'd657) begin
            bad++;
            $display("FAIL hsync_fall_addr: h_addr=%0d want 657", h_addr[0]);
          end
        end else if (fall1 < 0) fall1 = k;
      end
      if (prev === 1'b0 && hsync[0] === 1'b1 && fall0 >= 0 && rise0 < 0) rise0 = k;
      prev = hsync[0];
    end
    total++;
    if (rise0 - fall0 !== 96) begin
      bad++;
      $display("FAIL hsync_low_full: got %0d want 96", rise0 - fall0);
    end
    total++;
    if (fall1 - fall0 !== 800) begin
      bad++;
      $display("FAIL line_period_full: got %0d want 800", fall1 - fall0);
    end
    total++;
    if (sb_err !== 0) begin
      bad++;
      $display("FAIL full_rate_trace: %0d bad cycles, first dut%0d got %h want %h",
               sb_err, sb_dut, sb_obs, sb_exp);
    end
  endtask

  task automatic test_half_rate();
    int fall0, fall1, rise0;
    logic prev;
    sb_clear();
    do_reset();
    fall0 = -1; fall1 = -1; rise0 = -1;
    prev = hsync[0];
    for (int k = 0; k < 3400; k++) begin
      clken = (k % 2 == 0);
      vga_data = 12'($urandom);
      tick();
      if (prev === 1'b1 && hsync[0] === 1'b0) begin
        if (fall0 < 0) fall0 = k;
        else if (fall1 < 0) fall1 = k;
      end
      if (prev === 1'b0 && hsync[0] === 1'b1 && fall0 >= 0 && rise0 < 0) rise0 = k;
      prev = hsync[0];
    end
    clken = 1'b1;
    total++;
    if (rise0 - fall0 !== 192) begin
      bad++;
      $display("FAIL hsync_low_half: got %0d want 192", rise0 - fall0);
    end
    total++;
    if (fall1 - fall0 !== 1600) begin
      bad++;
      $display("FAIL line_period_half: got %0d want 1600", fall1 - fall0);
    end
    total++;
    if (sb_err !== 0) begin
      bad++;
      $display("FAIL half_rate_trace: %0d bad cycles, first dut%0d got %h want %h",
               sb_err, sb_dut, sb_obs, sb_exp);
    end
  endtask

  task automatic test_frame();
    int t0, t1, ticks_b, ticks_a, vs_low, vfall_v;
    logic prev_vs;
    sb_clear();
    do_reset();
    t0 = -1; t1 = -1; ticks_b = 0; ticks_a = 0; vs_low = 0; vfall_v = -1;
    prev_vs = vsync[1];
    for (int k = 0; k < 2200; k++) begin
      vga_data = 12'($urandom);
      tick();
      if (frame_tick[1] === 1'b1) begin
        ticks_b++;
        if (t0 < 0) t0 = k;
        else if (t1 < 0) t1 = k;
      end
      if (frame_tick[0] === 1'b1) ticks_a++;
      if (k < 1064 && vsync[1] === 1'b0) vs_low++;
      if (prev_vs === 1'b1 && vsync[1] === 1'b0 && vfall_v < 0) vfall_v = int'(v_addr[1]);
      prev_vs = vsync[1];
    end
    total++;
    if (t1 - t0 !== 1064 || t0 !== 1063) begin
      bad++;
      $display("FAIL frame_interval: first=%0d gap=%0d want first=1063 gap=1064", t0, t1 - t0);
    end
    total++;
    if (ticks_b !== 2) begin
      bad++;
      $display("FAIL frame_tick_width: high cycles=%0d want 2", ticks_b);
    end
    total++;
    if (vs_low !== 112 || vfall_v !== 14) begin
      bad++;
      $display("FAIL vsync_window: low=%0d fall_line=%0d want 112 and 14", vs_low, vfall_v);
    end
    total++;
    if (ticks_a !== 0) begin
      bad++;
      $display("FAIL no_early_tick: got %0d want 0", ticks_a);
    end
    total++;
    if (sb_err !== 0) begin
      bad++;
      $display("FAIL frame_trace: %0d bad cycles, first dut%0d got %h want %h",
               sb_err, sb_dut, sb_obs, sb_exp);
    end
  endtask

  task automatic test_blanking();
    int vis_a, vis_b, leak;
    sb_clear();
    vga_data = 12'hFFF;
    do_reset();
    vis_a = 0; vis_b = 0; leak = 0;
    for (int k = 0; k < 1064; k++) begin
      tick();
      if (k < 800 && valid[0] === 1'b1 && {vga_r[0], vga_g[0], vga_b[0]} === 12'hFFF) vis_a++;
      if (valid[1] === 1'b1 && {vga_r[1], vga_g[1], vga_b[1]} === 12'hFFF) vis_b++;
      for (int d = 0; d < 2; d++)
        if (valid[d] !== 1'b1 && {vga_r[d], vga_g[d], vga_b[d]} !== 12'h000) leak++;
    end
    total++;
    if (vis_a !== 640) begin
      bad++;
      $display("FAIL visible_per_line: got %0d want 640", vis_a);
    end
    total++;
    if (vis_b !== 480) begin
      bad++;
      $display("FAIL visible_per_frame_small: got %0d want 480", vis_b);
    end
    total++;
    if (leak !== 0) begin
      bad++;
      $display("FAIL blank_rgb_zero: nonzero blank cycles=%0d want 0", leak);
    end
  endtask

  task automatic test_mid_reset();
    logic [35:0] rst_vec;
    rst_vec = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    sb_clear();
    do_reset();
    // run to line 8, column 30 on the small instance
    for (int k = 0; k < 8 * 56 + 30; k++) begin
      vga_data = 12'($urandom);
      tick();
    end
    vga_data = 12'hFFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_vec(d) !== rst_vec) begin
        bad++;
        $display("FAIL mid_reset dut%0d: got %h want %h", d, obs_vec(d), rst_vec);
      end
    end
    tick();
    total++;
    if (valid[1] !== 1'b1 || h_addr[1] !== 10'd1 || v_addr[1] !== 10'd0 ||
        {vga_r[1], vga_g[1], vga_b[1]} !== 12'hFFF) begin
      bad++;
      $display("FAIL restart_at_origin: valid=%b h=%0d v=%0d rgb=%h want 1,1,0,fff",
               valid[1], h_addr[1], v_addr[1], {vga_r[1], vga_g[1], vga_b[1]});
    end
  endtask

  task automatic test_clken_hold();
    int hold_h, ft_seen;
    sb_clear();
    clken = 1'b1;
    for (int k = 0; k < 100; k++) begin
      vga_data = 12'($urandom);
      tick();
    end
    hold_h = cur_h(0);
    ft_seen = 0;
    clken = 1'b0;
    for (int k = 0; k < 50; k++) begin
      vga_data = 12'($urandom);
      tick();
      if (frame_tick[0] === 1'b1 || frame_tick[1] === 1'b1) ft_seen++;
    end
    total++;
    if (int'(h_addr[0]) !== hold_h || ft_seen !== 0) begin
      bad++;
      $display("FAIL hold_frozen: h=%0d ticks=%0d want h=%0d ticks=0", h_addr[0], ft_seen, hold_h);
    end
    clken = 1'b1;
    tick();
    total++;
    if (int'(h_addr[0]) !== hold_h + 1) begin
      bad++;
      $display("FAIL hold_resume: h=%0d want %0d", h_addr[0], hold_h + 1);
    end
    total++;
    if (sb_err !== 0) begin
      bad++;
      $display("FAIL hold_trace: %0d bad cycles, first dut%0d got %h want %h",
               sb_err, sb_dut, sb_obs, sb_exp);
    end
  endtask

  task automatic test_random();
    sb_clear();
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      clken = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 999) == 0);
      vga_data = 12'($urandom);
      tick();
    end
    rst = 1'b0;
    total++;
    if (sb_err !== 0) begin
      bad++;
      $display("FAIL random_trace: %0d bad cycles, first dut%0d got %h want %h",
               sb_err, sb_dut, sb_obs, sb_exp);
    end
  endtask

  initial begin
    sb_clear();
    test_reset();
    test_full_rate();
    test_half_rate();
    test_frame();
    test_blanking();
    test_mid_reset();
    test_clken_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
